// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encoding,
// host command codes and the halt opcode seen by the decode stage.
package cpu_ctrl_pkg;

  // Controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FLUSH = 3'd3,
    ST_RUN   = 3'd4,
    ST_STEP  = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

  // Host command codes on cmd_code.
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_STEP = 2'b11;

  // Opcode the core decodes as halt; the core raises halt_req on it.
  localparam logic [6:0] HALT_OPCODE = 7'h00;

  // Width of a counter that indexes n items (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_run_controller_byte_word_assembler.sv
// Byte-to-word assembler: shifts accepted bytes into a word buffer,
// little-endian (first byte lands in the low byte), and flags the
// byte that completes a word.
module byte_word_assembler
  import cpu_ctrl_pkg::*;
#(
  parameter int INS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 byte_accept,
  input  logic [7:0]           byte_data,
  output logic [INS_WIDTH-1:0] word,
  output logic                 word_done
);

  localparam int NBYTES = INS_WIDTH / 8;
  localparam int CW     = cnt_width(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [CW-1:0] byte_cnt;

  // The byte that fills the last slot completes the word.
  assign word_done = byte_accept && (byte_cnt == LAST);

  // Byte counter: cleared on load entry, wraps after the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      byte_cnt <= '0;
    else if (clear)
      byte_cnt <= '0;
    else if (byte_accept)
      byte_cnt <= (byte_cnt == LAST) ? '0 : byte_cnt + 1'b1;
  end

  // Shift-in buffer: new bytes enter at the top and move down, so after
  // NBYTES bytes the first one sits in bits [7:0].
  generate
    if (NBYTES > 1) begin : g_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          word <= '0;
        else if (clear)
          word <= '0;
        else if (byte_accept)
          word <= {byte_data, word[INS_WIDTH-1:8]};
      end
    end else begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          word <= '0;
        else if (clear)
          word <= '0;
        else if (byte_accept)
          word <= byte_data;
      end
    end
  endgenerate

endmodule

// File: rtl/cpu_run_controller.sv
// CPU run controller: program load from a byte stream, run / stop /
// single-step / halt sequencing and pipeline enable/flush generation.
// Optional build macro CYCLE_COUNT_EN adds a saturating count of cycles
// with the pipeline enabled (cycle_count), cleared by reset and FLUSH.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ADD_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int INS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_code,
  output logic                 cmd_ready,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  input  logic                 halt_req,
  output logic                 pmem_wen,
  output logic [ADD_WIDTH-1:0] pmem_wadd,
  output logic [INS_WIDTH-1:0] pmem_wdata,
  output logic                 pipe_en,
  output logic                 pipe_flush,
`ifdef CYCLE_COUNT_EN
  output logic [15:0]          cycle_count,
`endif
  output logic                 halted
);

  localparam logic [ADD_WIDTH-1:0] LAST_ADD = ADD_WIDTH'(DEPTH - 1);

  state_t               state, state_nxt;
  logic [ADD_WIDTH-1:0] word_cnt;
  logic                 asm_clear;
  logic                 byte_accept;
  logic                 word_done;
  logic [INS_WIDTH-1:0] word_buf;

  assign byte_accept = byte_valid && byte_ready;
  assign pmem_wadd   = word_cnt;
  assign pmem_wdata  = word_buf;

  byte_word_assembler #(.INS_WIDTH(INS_WIDTH)) u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (asm_clear),
    .byte_accept (byte_accept),
    .byte_data   (byte_data),
    .word        (word_buf),
    .word_done   (word_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore output decode. cmd_ready is held low while
  // reset is asserted so every output reads 0 during reset.
  always_comb begin
    state_nxt  = state;
    asm_clear  = 1'b0;
    cmd_ready  = 1'b0;
    byte_ready = 1'b0;
    pmem_wen   = 1'b0;
    pipe_en    = 1'b0;
    pipe_flush = 1'b0;
    halted     = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        cmd_ready = !rst;
        halted    = (state == ST_HALT);
        if (cmd_valid) begin
          unique case (cmd_code)
            CMD_STOP: state_nxt = ST_IDLE;
            CMD_LOAD: begin
              state_nxt = ST_LOAD;
              asm_clear = 1'b1;
            end
            CMD_RUN:  state_nxt = ST_RUN;
            default:  state_nxt = ST_STEP;
          endcase
        end
      end
      ST_LOAD: begin
        byte_ready = 1'b1;
        if (word_done) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        pmem_wen  = 1'b1;
        state_nxt = (word_cnt == LAST_ADD) ? ST_FLUSH : ST_LOAD;
      end
      ST_FLUSH: begin
        pipe_flush = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_RUN: begin
        pipe_en   = 1'b1;
        cmd_ready = !rst;
        // Halt takes priority over a simultaneous STOP; other commands
        // are accepted and dropped.
        if (halt_req)
          state_nxt = ST_HALT;
        else if (cmd_valid && cmd_code == CMD_STOP)
          state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        pipe_en   = 1'b1;
        state_nxt = halt_req ? ST_HALT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Word counter: cleared on load entry, advances per written word and
  // is forced back to 0 in FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      word_cnt <= '0;
    else if (asm_clear || state == ST_FLUSH)
      word_cnt <= '0;
    else if (state == ST_WRITE)
      word_cnt <= word_cnt + 1'b1;
  end

`ifdef CYCLE_COUNT_EN
  // Saturating count of pipeline-enabled cycles since the last load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cycle_count <= '0;
    else if (state == ST_FLUSH)
      cycle_count <= '0;
    else if (pipe_en && cycle_count != 16'hFFFF)
      cycle_count <= cycle_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed/random bench for cpu_run_controller. Expected program words
// come from the streamed byte array, expected pipe_en counts from the
// command timing; a negedge monitor records writes, flushes and enables.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_code = 2'b00;
  logic        cmd_ready;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        halt_req = 1'b0;
  logic        pmem_wen;
  logic [3:0]  pmem_wadd;
  logic [31:0] pmem_wdata;
  logic        pipe_en;
  logic        pipe_flush;
  logic        halted;
`ifdef CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  always #5 clk = ~clk;

  cpu_run_controller #(.ADD_WIDTH(4), .DEPTH(16), .INS_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .halt_req   (halt_req),
    .pmem_wen   (pmem_wen),
    .pmem_wadd  (pmem_wadd),
    .pmem_wdata (pmem_wdata),
    .pipe_en    (pipe_en),
    .pipe_flush (pipe_flush),
`ifdef CYCLE_COUNT_EN
    .cycle_count(cycle_count),
`endif
    .halted     (halted)
  );

  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
  wr_t  wq[$];
  int   pe_cnt = 0, flush_cnt = 0, wen_viol = 0, wen_long = 0, pe_at_flush = 0;
  bit   wen_prev = 0;
  logic [7:0] prog [64];
  int   errs = 0, checks = 0;

  // Monitor: record observable events mid-cycle.
  always @(negedge clk) begin
    if (pipe_en) pe_cnt++;
    if (pipe_flush) begin flush_cnt++; pe_at_flush = pe_cnt; end
    if (pmem_wen) begin
      wq.push_back('{pmem_wadd, pmem_wdata});
      if (byte_ready) wen_viol++;
      if (wen_prev) wen_long++;
    end
    wen_prev = pmem_wen;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1; cmd_code = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Stream prog[0..n-1]; each byte is held until the handshake completes.
  task automatic stream(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int to = 0;
      if (gaps) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      byte_valid = 1'b1; byte_data = prog[i];
      while (!byte_ready && to < 20) begin tick(); to++; end
      if (to >= 20) begin chk("byte_timeout", byte_ready, 1); break; end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  // Compare recorded writes against words built from the byte array.
  task automatic check_prog(input int fl0);
    logic [31:0] exp;
    repeat (3) tick();
    chk("wr_count", wq.size(), 16);
    for (int i = 0; i < 16 && i < wq.size(); i++) begin
      exp = 32'(prog[4*i]) + (32'(prog[4*i+1]) << 8) +
            (32'(prog[4*i+2]) << 16) + (32'(prog[4*i+3]) << 24);
      chk($sformatf("wr_addr%0d", i), wq[i].a, i);
      chk($sformatf("wr_data%0d", i), wq[i].d, exp);
    end
    chk("flush_once", flush_cnt - fl0, 1);
    chk("wen_vs_byte_ready", wen_viol, 0);
    chk("wen_single_cycle", wen_long, 0);
    chk("load_end_idle", {cmd_ready, byte_ready, pipe_en, halted}, 4'b1000);
  endtask

  task automatic run_halt(input int h);
    int pe0;
    pe0 = pe_cnt;
    send_cmd(2'b10);
    repeat (h) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk($sformatf("halted_after_h%0d", h), {halted, pipe_en}, 2'b10);
    tick();
    chk($sformatf("pe_cycles_h%0d", h), pe_cnt - pe0, h + 1);
    chk("halt_holds", halted, 1);
  endtask

  initial begin
    int fl0, pe0;
    // Reset state.
    #1 rst = 1'b1; #1;
    chk("reset_outputs", {cmd_ready, byte_ready, pmem_wen, pipe_en, pipe_flush,
        halted, pmem_wadd, pmem_wdata}, '0);
    tick(); tick();
    rst = 1'b0; tick();
    chk("post_reset_idle", {cmd_ready, byte_ready, pipe_en, halted}, 4'b1000);

    // Load 0x00..0x3F without gaps.
    for (int i = 0; i < 64; i++) prog[i] = 8'(i);
    wq.delete(); fl0 = flush_cnt;
    send_cmd(2'b01);
    stream(64, 0);
    check_prog(fl0);
    chk("addr0_const", wq[0].d, 32'h03020100);
    chk("addr15_const", wq[15].d, 32'h3F3E3D3C);

    // Same data with random gaps; a RUN during LOAD is dropped.
    wq.delete(); fl0 = flush_cnt;
    send_cmd(2'b01);
    cmd_valid = 1'b1; cmd_code = 2'b10; tick(); tick(); cmd_valid = 1'b0;
    chk("drop_cmd_in_load", {byte_ready, pipe_en, cmd_ready}, 3'b100);
    stream(64, 1);
    check_prog(fl0);

    // RUN with halt at cycle 5, then a random halt point.
    run_halt(5);
    pe0 = pe_cnt;
    send_cmd(2'b11);
    chk("step_active", {pipe_en, halted, cmd_ready}, 3'b100);
    tick();
    chk("step_one_cycle", pe_cnt - pe0, 1);
    chk("step_to_idle", {cmd_ready, pipe_en, halted}, 3'b100);
    run_halt($urandom_range(0, 20));
    send_cmd(2'b00);
    chk("stop_clears_halt", {cmd_ready, halted}, 2'b10);

    // Commands ignored in RUN; STOP+halt together halts.
    send_cmd(2'b10);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_code = (i == 0) ? 2'b10 : (i == 1) ? 2'b01 : 2'b11;
      tick();
      chk($sformatf("run_ignore%0d", i), {pipe_en, byte_ready, halted, cmd_ready}, 4'b1001);
    end
    cmd_code = 2'b00; halt_req = 1'b1; tick();
    cmd_valid = 1'b0; halt_req = 1'b0;
    chk("halt_beats_stop", {halted, pipe_en}, 2'b10);
    send_cmd(2'b00);
    send_cmd(2'b10); tick();
    send_cmd(2'b00);
    chk("run_stop_idle", {cmd_ready, pipe_en, halted}, 3'b100);

    // Reset after 2 bytes of word 5.
    for (int i = 0; i < 64; i++) prog[i] = 8'($urandom);
    wq.delete();
    send_cmd(2'b01);
    stream(22, 0);
    chk("words_before_rst", wq.size(), 5);
    #1 rst = 1'b1; #1;
    chk("async_rst_outputs", {cmd_ready, byte_ready, pmem_wen, pipe_en, pipe_flush,
        halted, pmem_wadd, pmem_wdata}, '0);
    tick(); rst = 1'b0; tick();
    wq.delete(); fl0 = flush_cnt;
    send_cmd(2'b01);
    stream(64, 1);
    check_prog(fl0);

`ifdef CYCLE_COUNT_EN
    chk("cc_after_flush", cycle_count, 0);
    send_cmd(2'b10);
    repeat (9) tick();
    send_cmd(2'b00);
    chk("cc_model", cycle_count, ((pe_cnt - pe_at_flush) > 65535) ? 65535 : (pe_cnt - pe_at_flush));
    chk("cc_ten", cycle_count, 10);
    wq.delete(); fl0 = flush_cnt;
    send_cmd(2'b01);
    stream(64, 0);
    check_prog(fl0);
    chk("cc_cleared_by_flush", cycle_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the pipelined 16-bit-result RISC-V core: program load, run, stop, single-step and halt.
- Program load: serially loads the 16x32 program memory from a byte stream.
- Pipeline control: gates the pipeline registers (PC, fetch, decode, writeback) with one enable and issues one-cycle flush pulses.
- Sits between the host/debug interface and the core top level.

Parameters:
- ADD_WIDTH, 4, program memory address width.
- DEPTH, 16, number of program words to load (must equal 2**ADD_WIDTH).
- INS_WIDTH, 32, instruction width (multiple of 8).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command strobe.
- cmd_code  input  2  command: 00 STOP, 01 LOAD, 10 RUN, 11 STEP.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- byte_valid  input  1  load byte strobe.
- byte_data  input  8  load byte.
- byte_ready  output  1  byte accepted when byte_valid && byte_ready.
- halt_req  input  1  core decode stage holds opcode 7'h00 (halt).
- pmem_wen  output  1  program memory write enable.
- pmem_wadd  output  ADD_WIDTH  program memory write address.
- pmem_wdata  output  INS_WIDTH  program memory write data.
- pipe_en  output  1  enable for all pipeline registers.
- pipe_flush  output  1  synchronous clear of PC and stage registers.
- halted  output  1  controller is in HALT.

Behaviour:
- States: IDLE, LOAD, WRITE, FLUSH, RUN, STEP, HALT. Reset -> IDLE.
- Reset values: all outputs 0; byte counter and word counter 0; word buffer 0.
- Outputs are Moore-decoded from state (pmem_wadd/pmem_wdata are the registered word counter and buffer):
  - pipe_en = RUN or STEP.
  - pipe_flush = FLUSH.
  - pmem_wen = WRITE.
  - halted = HALT.
  - byte_ready = LOAD.
  - cmd_ready = IDLE, RUN or HALT.
- IDLE/HALT commands:
  - LOAD -> LOAD; byte and word counters cleared.
  - RUN -> RUN; continues from the current PC.
  - STEP -> STEP.
  - STOP -> IDLE (clears HALT).
- LOAD byte assembly, little-endian: byte k (k = 0..3) goes to bits [8k+7:8k]. On the 4th accepted byte, next state WRITE.
- WRITE: lasts exactly 1 cycle.
  - pmem_wadd = word counter, pmem_wdata = assembled word.
  - Word counter increments.
  - If the written address was DEPTH-1 -> FLUSH, else -> LOAD.
- FLUSH: exactly 1 cycle, then IDLE. Word counter wraps to 0.
- RUN: pipe_en = 1 every cycle.
  - halt_req = 1 -> HALT next edge; pipe_en is still 1 in that cycle, so the pipeline advances once more.
  - Accepted STOP -> IDLE next edge.
  - LOAD, RUN and STEP are accepted but ignored.
  - halt_req and STOP in the same cycle: HALT wins.
- STEP: pipe_en = 1 for exactly 1 cycle.
  - halt_req seen in STEP -> HALT; otherwise -> IDLE.
- halt_req is ignored outside RUN and STEP.
- Reset mid-LOAD: partial word is discarded; words already written stay in memory; state -> IDLE.
- cmd_valid while cmd_ready = 0 is dropped, not queued.
- Word width rule: byte counter is log2(INS_WIDTH/8) bits and wraps naturally.

Optional Feature:
- Macro: CYCLE_COUNT_EN.
- Defined: adds output cycle_count [15:0].
  - Increments each cycle pipe_en = 1, saturates at 16'hFFFF.
  - Cleared by reset and FLUSH; holds otherwise.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - State encoding localparams (3-bit: IDLE=0, LOAD=1, WRITE=2, FLUSH=3, RUN=4, STEP=5, HALT=6).
  - Command code constants CMD_STOP=2'b00, CMD_LOAD=2'b01, CMD_RUN=2'b10, CMD_STEP=2'b11.
  - HALT_OPCODE = 7'h00.
- One sub-module, byte_word_assembler:
  - Contains the byte counter, shift-in buffer and word_done flag.
  - Parameterised by INS_WIDTH; clear input driven by LOAD entry.

Test Plan:
- Reset then LOAD, stream 64 bytes 0x00..0x3F: 16 single-cycle pmem_wen pulses; address 0 data 32'h03020100, address 15 data 32'h3F3E3D3C; FLUSH pulse once; ends in IDLE.
- Byte_valid gaps during LOAD (random idle cycles): same writes and data as above; byte_ready low exactly in WRITE cycles.
- RUN, assert halt_req at cycle 5: pipe_en high 6 cycles; halted = 1 from next cycle; then STEP gives exactly one pipe_en cycle and returns to IDLE.
- RUN with STOP and halt_req in the same cycle: ends in HALT, not IDLE; RUN/LOAD commands during RUN produce no state change.
- Assert rst after 2 bytes of word 5: all outputs 0 immediately (async); new LOAD writes address 0 with freshly streamed data.
- With CYCLE_COUNT_EN: RUN for 10 cycles then STOP gives cycle_count = 10; LOAD completion (FLUSH) resets it to 0.
